// File: rtl/fusion_dot_ctrl.sv
// Dot-product sequencer for one combinational fusion_unit: streams operand pairs
// into registered fu_* inputs and sums each psum_fwd into an ACC_W-bit accumulator.
module fusion_dot_ctrl #(
  parameter int ACC_W = 32,
  parameter int LEN_W = 10
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [3:0]       cfg_in_width_i,
  input  logic [3:0]       cfg_weight_width_i,
  input  logic             cfg_s_in_i,
  input  logic             cfg_s_weight_i,
  input  logic [LEN_W-1:0] cfg_len_i,
  output logic             busy_o,
  output logic             cfg_err_o,
  input  logic             op_valid_i,
  output logic             op_ready_o,
  input  logic [7:0]       op_in_i,
  input  logic [7:0]       op_weight_i,
  output logic [7:0]       fu_in_o,
  output logic [7:0]       fu_weight_o,
  output logic [3:0]       fu_in_width_o,
  output logic [3:0]       fu_weight_width_o,
  output logic             fu_s_in_o,
  output logic             fu_s_weight_o,
  input  logic [15:0]      fu_psum_i,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic [ACC_W-1:0] res_data_o
);

  // state | meaning
  // IDLE  | waiting for a start with legal widths
  // RUN   | accepting operand pairs, accumulating the previous pair's psum
  // DRAIN | last pair sits in fu_*; its psum is added this cycle
  // DONE  | result held on res_data until the consumer takes it
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [LEN_W-1:0]   count_q, count_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               pipe_v_q, pipe_v_d;
  logic               cfg_err_q, cfg_err_d;
  logic [7:0]         fu_in_q, fu_in_d;
  logic [7:0]         fu_weight_q, fu_weight_d;
  logic [3:0]         fu_in_width_q, fu_in_width_d;
  logic [3:0]         fu_weight_width_q, fu_weight_width_d;
  logic               fu_s_in_q, fu_s_in_d;
  logic               fu_s_weight_q, fu_s_weight_d;

  logic               start_ok;
  logic               hs;
  logic [LEN_W-1:0]   count_inc;
  logic [ACC_W-1:0]   psum_ext;

  function automatic logic width_ok(input logic [3:0] w);
    return (w == 4'd2) || (w == 4'd4) || (w == 4'd8);
  endfunction

  assign start_ok  = width_ok(cfg_in_width_i) && width_ok(cfg_weight_width_i);
  assign hs        = (state_q == RUN) && op_valid_i;
  assign count_inc = count_q + LEN_W'(1);
  // psum is signed whenever either operand is signed
  assign psum_ext  = (fu_s_in_q | fu_s_weight_q) ? ACC_W'($signed(fu_psum_i))
                                                 : ACC_W'(fu_psum_i);

  always_comb begin
    state_d           = state_q;
    acc_d             = acc_q;
    count_d           = count_q;
    len_d             = len_q;
    pipe_v_d          = 1'b0;
    cfg_err_d         = 1'b0;
    fu_in_d           = fu_in_q;
    fu_weight_d       = fu_weight_q;
    fu_in_width_d     = fu_in_width_q;
    fu_weight_width_d = fu_weight_width_q;
    fu_s_in_d         = fu_s_in_q;
    fu_s_weight_d     = fu_s_weight_q;

    if (pipe_v_q) acc_d = acc_q + psum_ext;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          if (start_ok) begin
            fu_in_width_d     = cfg_in_width_i;
            fu_weight_width_d = cfg_weight_width_i;
            fu_s_in_d         = cfg_s_in_i;
            fu_s_weight_d     = cfg_s_weight_i;
            acc_d             = '0;
            count_d           = '0;
            len_d             = cfg_len_i;
            state_d           = (cfg_len_i == '0) ? DONE : RUN;
          end else begin
            cfg_err_d = 1'b1;
          end
        end
      end
      RUN: begin
        if (hs) begin
          fu_in_d     = op_in_i;
          fu_weight_d = op_weight_i;
          pipe_v_d    = 1'b1;
          count_d     = count_inc;
          if (count_inc == len_q) state_d = DRAIN;
        end
      end
      DRAIN:   state_d = DONE;
      DONE:    if (res_ready_i) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q           <= IDLE;
      acc_q             <= '0;
      count_q           <= '0;
      len_q             <= '0;
      pipe_v_q          <= 1'b0;
      cfg_err_q         <= 1'b0;
      fu_in_q           <= '0;
      fu_weight_q       <= '0;
      fu_in_width_q     <= 4'd8;
      fu_weight_width_q <= 4'd8;
      fu_s_in_q         <= 1'b0;
      fu_s_weight_q     <= 1'b0;
    end else begin
      state_q           <= state_d;
      acc_q             <= acc_d;
      count_q           <= count_d;
      len_q             <= len_d;
      pipe_v_q          <= pipe_v_d;
      cfg_err_q         <= cfg_err_d;
      fu_in_q           <= fu_in_d;
      fu_weight_q       <= fu_weight_d;
      fu_in_width_q     <= fu_in_width_d;
      fu_weight_width_q <= fu_weight_width_d;
      fu_s_in_q         <= fu_s_in_d;
      fu_s_weight_q     <= fu_s_weight_d;
    end
  end

  assign busy_o            = (state_q != IDLE);
  assign op_ready_o        = (state_q == RUN);
  assign res_valid_o       = (state_q == DONE);
  assign res_data_o        = acc_q;
  assign cfg_err_o         = cfg_err_q;
  assign fu_in_o           = fu_in_q;
  assign fu_weight_o       = fu_weight_q;
  assign fu_in_width_o     = fu_in_width_q;
  assign fu_weight_width_o = fu_weight_width_q;
  assign fu_s_in_o         = fu_s_in_q;
  assign fu_s_weight_o     = fu_s_weight_q;

endmodule

// File: tb/tb_fusion_dot_ctrl.sv
// Bench for fusion_dot_ctrl: a transaction-level dot-product model checked every
// cycle, plus directed jobs with hand-computed sums and random jobs.
module tb_fusion_dot_ctrl;
  localparam int ACC_W = 32;
  localparam int LEN_W = 10;

  logic             clk_i = 1'b0;
  logic             rst_i;
  logic             start_i;
  logic [3:0]       cfg_in_width_i, cfg_weight_width_i;
  logic             cfg_s_in_i, cfg_s_weight_i;
  logic [LEN_W-1:0] cfg_len_i;
  logic             busy_o, cfg_err_o;
  logic             op_valid_i, op_ready_o;
  logic [7:0]       op_in_i, op_weight_i;
  logic [7:0]       fu_in_o, fu_weight_o;
  logic [3:0]       fu_in_width_o, fu_weight_width_o;
  logic             fu_s_in_o, fu_s_weight_o;
  logic [15:0]      fu_psum_i;
  logic             res_valid_o, res_ready_i;
  logic [ACC_W-1:0] res_data_o;

  fusion_dot_ctrl #(.ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .start_i(start_i),
    .cfg_in_width_i(cfg_in_width_i), .cfg_weight_width_i(cfg_weight_width_i),
    .cfg_s_in_i(cfg_s_in_i), .cfg_s_weight_i(cfg_s_weight_i), .cfg_len_i(cfg_len_i),
    .busy_o(busy_o), .cfg_err_o(cfg_err_o),
    .op_valid_i(op_valid_i), .op_ready_o(op_ready_o),
    .op_in_i(op_in_i), .op_weight_i(op_weight_i),
    .fu_in_o(fu_in_o), .fu_weight_o(fu_weight_o),
    .fu_in_width_o(fu_in_width_o), .fu_weight_width_o(fu_weight_width_o),
    .fu_s_in_o(fu_s_in_o), .fu_s_weight_o(fu_s_weight_o),
    .fu_psum_i(fu_psum_i),
    .res_valid_o(res_valid_o), .res_ready_i(res_ready_i), .res_data_o(res_data_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic int opval(input logic [7:0] v, input logic s);
    return s ? int'($signed(v)) : int'({24'd0, v});
  endfunction

  // stand-in fusion_unit: full 8x8 product, truncated to the 16-bit psum bus
  assign fu_psum_i = 16'(opval(fu_in_o, fu_s_in_o) * opval(fu_weight_o, fu_s_weight_o));

  int total = 0;
  int bad   = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level model ----------------
  typedef enum int {P_IDLE, P_RUN, P_DRAIN, P_DONE} phase_t;
  phase_t      m_ph;
  logic [31:0] m_sum;
  int          m_left, m_taken;
  logic        m_err, m_si, m_sw;
  logic [3:0]  m_iw, m_ww;
  logic [7:0]  m_fin, m_fw;

  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      m_ph = P_IDLE; m_sum = '0; m_left = 0; m_taken = 0; m_err = 1'b0;
      m_iw = 4'd8; m_ww = 4'd8; m_si = 1'b0; m_sw = 1'b0; m_fin = '0; m_fw = '0;
    end else begin
      m_err = 1'b0;
      case (m_ph)
        P_IDLE: if (start_i) begin
          if ((cfg_in_width_i inside {4'd2, 4'd4, 4'd8}) &&
              (cfg_weight_width_i inside {4'd2, 4'd4, 4'd8})) begin
            m_iw = cfg_in_width_i; m_ww = cfg_weight_width_i;
            m_si = cfg_s_in_i; m_sw = cfg_s_weight_i;
            m_sum = '0; m_taken = 0; m_left = int'(cfg_len_i);
            m_ph = (m_left == 0) ? P_DONE : P_RUN;
          end else m_err = 1'b1;
        end
        P_RUN: if (op_valid_i) begin
          m_fin = op_in_i; m_fw = op_weight_i;
          m_sum = m_sum + 32'(opval(op_in_i, m_si) * opval(op_weight_i, m_sw));
          m_taken++; m_left--;
          if (m_left == 0) m_ph = P_DRAIN;
        end
        P_DRAIN: m_ph = P_DONE;
        P_DONE:  if (res_ready_i) m_ph = P_IDLE;
        default: m_ph = P_IDLE;
      endcase
    end
  end

  bit chk_en = 1'b0;
  always @(negedge clk_i) if (chk_en) begin
    check("busy", busy_o, m_ph != P_IDLE);
    check("op_ready", op_ready_o, m_ph == P_RUN);
    check("res_valid", res_valid_o, m_ph == P_DONE);
    check("cfg_err", cfg_err_o, m_err);
    check("fu_in", fu_in_o, m_fin);
    check("fu_weight", fu_weight_o, m_fw);
    check("fu_cfg", {fu_in_width_o, fu_weight_width_o, fu_s_in_o, fu_s_weight_o},
          {m_iw, m_ww, m_si, m_sw});
    if (m_ph == P_IDLE || m_ph == P_DONE) check("res_data", res_data_o, m_sum);
  end

  // ---------------- stimulus ----------------
  logic [7:0] pin[64], pw[64];
  bit         vpat[$];

  task automatic run_job(input logic [3:0] iw, input logic [3:0] ww, input logic si,
                         input logic sw, input int len, input bit rand_v, input int rr_wait,
                         input bit start_in_done, input bit use_lit, input logic [31:0] lit);
    int b;
    @(negedge clk_i);
    start_i = 1'b1; cfg_in_width_i = iw; cfg_weight_width_i = ww;
    cfg_s_in_i = si; cfg_s_weight_i = sw; cfg_len_i = LEN_W'(len);
    @(negedge clk_i);
    start_i = 1'b0;
    if (len == 0) begin
      check("len0_res_valid", res_valid_o, 1'b1);
      check("len0_op_ready", op_ready_o, 1'b0);
    end else begin
      b = 0;
      while (m_ph == P_RUN && b < 400) begin
        if (vpat.size() > 0) op_valid_i = vpat.pop_front();
        else op_valid_i = rand_v ? ($urandom_range(0, 3) != 0) : 1'b1;
        op_in_i = pin[m_taken]; op_weight_i = pw[m_taken];
        @(negedge clk_i);
        b++;
      end
      op_valid_i = 1'b0;
      check("run_no_timeout", b < 400, 1'b1);
      // handshake edge counts as the first; res_valid follows the next edge
      check("lat_drain_rv0", res_valid_o, 1'b0);
      @(negedge clk_i);
      check("lat_rv1", res_valid_o, 1'b1);
    end
    b = 0;
    while (!res_valid_o && b < 8) begin @(negedge clk_i); b++; end
    check("res_valid_seen", res_valid_o, 1'b1);
    if (use_lit) check("res_literal", res_data_o, lit);
    repeat (rr_wait) begin
      if (start_in_done) begin start_i = 1'b1; cfg_len_i = LEN_W'(5); cfg_in_width_i = 4'd2; end
      @(negedge clk_i);
      start_i = 1'b0;
    end
    if (start_in_done) check("start_in_done_busy", busy_o, 1'b1);
    res_ready_i = 1'b1;
    @(negedge clk_i);
    res_ready_i = 1'b0;
    check("back_to_idle", busy_o, 1'b0);
  endtask

  initial begin
    logic [3:0] wsel[4];
    rst_i = 1'b1; start_i = 1'b0; cfg_in_width_i = 4'd8; cfg_weight_width_i = 4'd8;
    cfg_s_in_i = 1'b0; cfg_s_weight_i = 1'b0; cfg_len_i = '0;
    op_valid_i = 1'b0; op_in_i = '0; op_weight_i = '0; res_ready_i = 1'b0;
    repeat (2) @(negedge clk_i);
    check("rst_busy", busy_o, 1'b0);
    check("rst_op_ready", op_ready_o, 1'b0);
    check("rst_res_valid", res_valid_o, 1'b0);
    check("rst_widths", {fu_in_width_o, fu_weight_width_o}, 8'h88);
    check("rst_res_data", res_data_o, 32'd0);
    rst_i = 1'b0;
    chk_en = 1'b1;

    // illegal width rejected
    @(negedge clk_i);
    start_i = 1'b1; cfg_in_width_i = 4'd3; cfg_len_i = LEN_W'(2);
    @(negedge clk_i);
    start_i = 1'b0; cfg_in_width_i = 4'd8;
    check("err_pulse", cfg_err_o, 1'b1);
    check("err_busy", busy_o, 1'b0);
    check("err_in_width", fu_in_width_o, 4'd8);
    @(negedge clk_i);
    check("err_one_cycle", cfg_err_o, 1'b0);

    // unsigned 8x8: 15 + 200 + 65025
    pin[0] = 8'd3;   pw[0] = 8'd5;
    pin[1] = 8'd10;  pw[1] = 8'd20;
    pin[2] = 8'd255; pw[2] = 8'd255;
    run_job(4'd8, 4'd8, 1'b0, 1'b0, 3, 1'b0, 0, 1'b0, 1'b1, 32'd65240);

    // signed 8x8: -6 + -16256
    pin[0] = 8'hFE; pw[0] = 8'h03;
    pin[1] = 8'h80; pw[1] = 8'h7F;
    run_job(4'd8, 4'd8, 1'b1, 1'b1, 2, 1'b0, 1, 1'b0, 1'b1, 32'hFFFFC07A);

    run_job(4'd4, 4'd2, 1'b0, 1'b1, 0, 1'b0, 0, 1'b0, 1'b1, 32'd0);

    // backpressure: 2 + 12 + 30
    pin[0] = 8'd1; pw[0] = 8'd2;
    pin[1] = 8'd3; pw[1] = 8'd4;
    pin[2] = 8'd5; pw[2] = 8'd6;
    vpat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    run_job(4'd8, 4'd8, 1'b0, 1'b0, 3, 1'b0, 5, 1'b1, 1'b1, 32'd44);

    // reset mid-RUN
    pin[0] = 8'd7; pw[0] = 8'd9;
    pin[1] = 8'd11; pw[1] = 8'd13;
    @(negedge clk_i);
    start_i = 1'b1; cfg_in_width_i = 4'd4; cfg_weight_width_i = 4'd2;
    cfg_s_in_i = 1'b1; cfg_s_weight_i = 1'b0; cfg_len_i = LEN_W'(3);
    @(negedge clk_i);
    start_i = 1'b0; op_valid_i = 1'b1; op_in_i = pin[0]; op_weight_i = pw[0];
    @(negedge clk_i);
    op_in_i = pin[1]; op_weight_i = pw[1];
    @(posedge clk_i);
    #2 rst_i = 1'b1;
    #1;
    check("arst_busy", busy_o, 1'b0);
    check("arst_op_ready", op_ready_o, 1'b0);
    check("arst_fu_ops", {fu_in_o, fu_weight_o}, 16'd0);
    check("arst_fu_cfg", {fu_in_width_o, fu_weight_width_o, fu_s_in_o, fu_s_weight_o}, 10'h220);
    check("arst_res", {res_valid_o, cfg_err_o, res_data_o}, 34'd0);
    @(negedge clk_i);
    rst_i = 1'b0; op_valid_i = 1'b0;
    pin[0] = 8'd2; pw[0] = 8'd3;
    run_job(4'd8, 4'd8, 1'b0, 1'b0, 1, 1'b0, 0, 1'b0, 1'b1, 32'd6);

    // random jobs with occasional illegal starts
    wsel = '{4'd2, 4'd4, 4'd8, 4'd8};
    for (int j = 0; j < 12; j++) begin
      int len;
      len = $urandom_range(1, 20);
      for (int k = 0; k < 64; k++) begin
        pin[k] = 8'($urandom); pw[k] = 8'($urandom);
      end
      if (j % 4 == 3) begin
        @(negedge clk_i);
        start_i = 1'b1; cfg_in_width_i = 4'($urandom_range(9, 15)); cfg_len_i = LEN_W'(len);
        @(negedge clk_i);
        start_i = 1'b0;
      end
      run_job(wsel[$urandom_range(0, 3)], wsel[$urandom_range(0, 3)],
              1'($urandom), 1'($urandom), len, 1'b1, $urandom_range(0, 3),
              1'($urandom), 1'b0, 32'd0);
    end

    repeat (2) @(negedge clk_i);
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0t required=<200000", $time);
    $fatal(1, "bench timeout");
  end

endmodule

// File: doc/fusion_dot_ctrl.md
Name: fusion_dot_ctrl

Overview:
Sequencer that drives one fusion_unit datapath through a dot-product of configurable length. Latches the precision and sign configuration on start, streams operand pairs from an upstream valid/ready source into registered fusion_unit inputs, and accumulates each psum_fwd into a wide accumulator. Returns the final sum over a valid/ready result port. Sits between the operand buffers and the fusion_unit; fusion_unit stays combinational and outside this block.

Parameters:
ACC_W, 32, accumulator and result width; must be >= 16
LEN_W, 10, width of the operand-pair count (maximum pairs 2^LEN_W-1)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  reset, asynchronous, active-high
start  input  1  begin a dot product; sampled only in IDLE
cfg_in_width  input  4  input precision; legal values 2, 4, 8
cfg_weight_width  input  4  weight precision; legal values 2, 4, 8
cfg_s_in  input  1  input operands signed
cfg_s_weight  input  1  weight operands signed
cfg_len  input  LEN_W  number of operand pairs
busy  output  1  high in every state except IDLE
cfg_err  output  1  one-cycle pulse when start is rejected
op_valid  input  1  operand pair valid
op_ready  output  1  block can accept a pair
op_in  input  8  packed input operand(s)
op_weight  input  8  packed weight operand(s)
fu_in  output  8  registered to fusion_unit in
fu_weight  output  8  registered to fusion_unit weight
fu_in_width  output  4  latched cfg_in_width
fu_weight_width  output  4  latched cfg_weight_width
fu_s_in  output  1  latched cfg_s_in
fu_s_weight  output  1  latched cfg_s_weight
fu_psum  input  16  fusion_unit psum_fwd, combinational from the fu_* outputs
res_valid  output  1  result valid
res_ready  input  1  result consumer ready
res_data  output  ACC_W  accumulated dot product

Behaviour:
- Reset values: state IDLE; busy=0; cfg_err=0; op_ready=0; fu_in=0; fu_weight=0; fu_in_width=8; fu_weight_width=8; fu_s_in=0; fu_s_weight=0; res_valid=0; acc=0; count=0; pipe_v=0.
- Reset is asynchronous and can be asserted in any state. All of the above take their reset values immediately. Any in-flight pair is discarded.
- States: IDLE, RUN, DRAIN, DONE.
- IDLE to RUN: start=1 and both widths legal. At that edge: latch the config into the fu_* config outputs, clear acc and count. If cfg_len=0, go directly to DONE with acc=0.
- IDLE with illegal width: on start=1 with any width not in {2,4,8}, cfg_err=1 for exactly the next cycle. State stays IDLE and the fu_* config outputs are unchanged.
- start is ignored outside IDLE.
- op_ready = (state==RUN). A handshake is op_valid & op_ready at a rising edge.
- On each handshake: fu_in<=op_in, fu_weight<=op_weight, pipe_v<=1, count<=count+1. With no handshake, pipe_v<=0 and fu_in/fu_weight hold their values.
- Accumulate: at each edge where pipe_v=1, acc <= acc + ext(fu_psum).
  - ext = sign-extend if (fu_s_in | fu_s_weight), else zero-extend.
  - acc wraps modulo 2^ACC_W; there is no saturation and no flag.
- Throughput: one pair per cycle. Gaps in op_valid are allowed.
- RUN to DRAIN: at the handshake where count+1 == latched len.
- DRAIN to DONE: after one cycle, during which the last psum is accumulated.
- Latency: res_valid rises 2 edges after the last handshake edge.
- DONE: res_valid=1 and res_data=acc, both held stable while res_ready=0. On res_valid & res_ready, go to IDLE and drop res_valid at that edge.
- res_data holds its last value in IDLE.

Test Plan:
- Unsigned 8x8, len=3, pairs (3,5),(10,20),(255,255), bench model psum=in*weight -> res_data=65240, with res_valid 2 edges after the 3rd handshake.
- Signed 8x8 (s_in=s_weight=1), len=2, pairs (0xFE,0x03),(0x80,0x7F) -> psums -6 and -16256 -> res_data=0xFFFFC07A.
- len=0, start -> DONE at the next edge, res_valid=1 with res_data=0, op_ready never asserted.
- Backpressure: op_valid toggled 1,0,0,1,1 for len=3, then res_ready held low 5 cycles -> correct sum, res_data stable, and a start issued during DONE is ignored (busy stays 1).
- cfg_in_width=3 with start -> cfg_err high for 1 cycle, busy=0, fu_in_width remains 8.
- rst asserted mid-RUN between clock edges -> all outputs return to reset values immediately. A following len=1 run on (2,3) gives res_data=6.
